// File: rtl/pipeline_pkg.sv
// Shared constants for the operand-forwarding pipeline: selector encodings,
// the hardwired-zero register and the stall counter width.
package pipeline_pkg;

    localparam int unsigned FWD_SEL_RF  = 0;
    localparam int unsigned REG_ZERO    = 0;
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/fwd_chan.sv
// One source-operand channel: matches its register against every tracked
// producer, picks the newest one and muxes the operand, or flags a load-use hazard.
module fwd_chan
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic [REG_AW-1:0]       src,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic [DEPTH-1:0]        tag_v,
    input  logic [DEPTH-1:0]        tag_wr,
    input  logic [DEPTH-1:0]        tag_load,
    input  logic [DEPTH*REG_AW-1:0] tag_dest,
    output logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       data,
    output logic                    hazard
);

    logic [DEPTH-1:0] match;
    logic             found;

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            match[k] = tag_v[k] && tag_wr[k]
                    && (tag_dest[k*REG_AW +: REG_AW] == src)
                    && (src != REG_AW'(REG_ZERO));
        end
    end

    // Scan from stage 0 upward so the newest producer claims the operand first.
    always_comb begin
        sel    = SEL_W'(FWD_SEL_RF);
        data   = reg_data;
        hazard = 1'b0;
        found  = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && match[k]) begin
                found = 1'b1;
                if (k == 0 && tag_load[k]) begin
                    hazard = 1'b1;
                end else begin
                    sel  = SEL_W'(k + 1);
                    data = stage_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/forward_unit_n.sv
// N-channel operand forwarding unit: tracks in-flight destination tags, selects
// the newest producer per source operand and raises the load-use stall.
module forward_unit_n
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REG_AW-1:0]         issue_dest,
    input  logic                      issue_load,
    input  logic                      flush,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] reg_data,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    output logic [NUM_SRC*DATA_W-1:0] operand,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cnt
);

    typedef struct packed {
        logic              v;
        logic              wr;
        logic [REG_AW-1:0] dest;
        logic              load;
    } tag_t;

    tag_t [DEPTH-1:0]        tags;
    tag_t [DEPTH-1:0]        tags_nxt;
    logic [DEPTH-1:0]        tag_v;
    logic [DEPTH-1:0]        tag_wr;
    logic [DEPTH-1:0]        tag_load;
    logic [DEPTH*REG_AW-1:0] tag_dest;
    logic [NUM_SRC-1:0]      hazard;
    logic                    stall_any;
    logic [STALL_CNT_W-1:0]  cnt;

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            tag_v[k]                      = tags[k].v;
            tag_wr[k]                     = tags[k].wr;
            tag_load[k]                   = tags[k].load;
            tag_dest[k*REG_AW +: REG_AW]  = tags[k].dest;
        end
    end

    // Flush overrides both a fresh issue and the stall-induced bubble.
    always_comb begin
        tags_nxt = '0;
        if (issue_valid && !stall_any) begin
            tags_nxt[0] = '{v: 1'b1, wr: issue_wr, dest: issue_dest, load: issue_load};
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            tags_nxt[k] = tags[k-1];
        end
        if (flush) begin
            tags_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tags <= '0;
        end else begin
            tags <= tags_nxt;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
        fwd_chan #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_chan (
            .src        (src_addr[i*REG_AW +: REG_AW]),
            .reg_data   (reg_data[i*DATA_W +: DATA_W]),
            .stage_data (stage_data),
            .tag_v      (tag_v),
            .tag_wr     (tag_wr),
            .tag_load   (tag_load),
            .tag_dest   (tag_dest),
            .sel        (fwd_sel[i*SEL_W +: SEL_W]),
            .data       (operand[i*DATA_W +: DATA_W]),
            .hazard     (hazard[i])
        );
    end

    assign stall_any = |hazard;
    assign stall     = stall_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (stall_any && !flush && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall_cnt = cnt;

endmodule
